// File: rtl/sid_dac_seq.sv
// Bit-serial SID-style R-2R DAC emulator: each channel's code is converted by summing
// per-bit ladder weights (two selectable banks), then rounded and saturated to BITS.
module sid_dac_seq #(
  parameter int BITS      = 12,
  parameter int CHANNELS  = 3,
  parameter int SCALEBITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          model,
  input  logic [CHANNELS*BITS-1:0]      vin,
  input  logic                          wr_en,
  input  logic                          wr_bank,
  input  logic [$clog2(BITS)-1:0]       wr_addr,
  input  logic [BITS+SCALEBITS-1:0]     wr_data,
  output logic                          busy,
  output logic                          valid,
  output logic [CHANNELS*BITS-1:0]      vout
);

  localparam int WW    = BITS + SCALEBITS;
  localparam int ACC_W = BITS + SCALEBITS + $clog2(BITS) + 1;
  localparam int BIT_W = $clog2(BITS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HALF  = 1 << (SCALEBITS - 1);
  localparam int MAXV  = (1 << BITS) - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state, state_nxt;
  logic [WW-1:0]              w [2][BITS];
  logic [CHANNELS*BITS-1:0]   vin_lat;
  logic                       model_lat;
  logic [ACC_W-1:0]           acc, acc_sum, add;
  logic [BIT_W-1:0]           bit_cnt;
  logic [CH_W-1:0]            chan_cnt;
  logic                       bit_last, chan_last;
  logic [BITS-1:0]            res;

  function automatic logic [ACC_W-1:0] round_half(input logic [ACC_W-1:0] a);
    return (a + ACC_W'(HALF)) >> SCALEBITS;
  endfunction

  function automatic logic [BITS-1:0] sat(input logic [ACC_W-1:0] a);
    if (a > ACC_W'(MAXV)) return '1;
    return a[BITS-1:0];
  endfunction

  assign bit_last  = (bit_cnt == BIT_W'(BITS - 1));
  assign chan_last = (chan_cnt == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (bit_last && chan_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // The latched code is consumed LSB-first, which walks channel 0 bit 0 .. last channel bit BITS-1.
  always_comb begin
    add = '0;
    if (vin_lat[0]) add = ACC_W'(w[model_lat][bit_cnt]);
    acc_sum = acc + add;
    res     = sat(round_half(acc_sum));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      vout      <= '0;
      vin_lat   <= '0;
      model_lat <= 1'b0;
      acc       <= '0;
      bit_cnt   <= '0;
      chan_cnt  <= '0;
      for (int b = 0; b < 2; b++)
        for (int n = 0; n < BITS; n++)
          w[b][n] <= WW'(1) << (n + SCALEBITS);
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        if (wr_en && (wr_addr <= BIT_W'(BITS - 1)))
          w[wr_bank][wr_addr] <= wr_data;
        if (start) begin
          vin_lat   <= vin;
          model_lat <= model;
          acc       <= '0;
          bit_cnt   <= '0;
          chan_cnt  <= '0;
        end
      end else begin
        vin_lat <= vin_lat >> 1;
        if (bit_last) begin
          for (int c = 0; c < CHANNELS; c++)
            if (chan_cnt == CH_W'(c)) vout[c*BITS +: BITS] <= res;
          acc     <= '0;
          bit_cnt <= '0;
          if (chan_last) begin
            valid    <= 1'b1;
            chan_cnt <= '0;
          end else begin
            chan_cnt <= chan_cnt + 1'b1;
          end
        end else begin
          acc     <= acc_sum;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_dac_seq.sv
// Bench for sid_dac_seq: a conversion-level model predicts busy/valid/vout every cycle,
// plus directed scenarios with hand-computed results and latencies.
module tb_sid_dac_seq;
  localparam int BITS = 12, CH = 3, SB = 4;

  logic                 clk = 0, rst_n = 0, start = 0, model = 0;
  logic [CH*BITS-1:0]   vin = '0;
  logic                 wr_en = 0, wr_bank = 0;
  logic [3:0]           wr_addr = '0;
  logic [BITS+SB-1:0]   wr_data = '0;
  logic                 busy, valid;
  logic [CH*BITS-1:0]   vout;

  int checks = 0, errors = 0;

  sid_dac_seq #(.BITS(BITS), .CHANNELS(CH), .SCALEBITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .model(model), .vin(vin),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .valid(valid), .vout(vout));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Conversion-level model: on accept, compute every channel's result from the weights
  // in force; publish channel c BITS*(c+1) edges later and pulse valid with the last one.
  int                 cyc = 0, t_acc = 0;
  int                 mw [2][BITS];
  int                 res [CH];
  logic               m_busy = 0, m_valid = 0;
  logic [CH*BITS-1:0] m_vout = '0;

  always @(posedge clk) begin
    int k, ch, s;
    logic was;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_vout = '0;
      for (int b = 0; b < 2; b++)
        for (int n = 0; n < BITS; n++) mw[b][n] = 1 << (n + SB);
    end else begin
      was = m_busy;
      m_valid = 0;
      if (was) begin
        k = cyc - t_acc;
        if (k % BITS == 0) begin
          ch = k / BITS - 1;
          m_vout[ch*BITS +: BITS] = res[ch][BITS-1:0];
          if (ch == CH - 1) begin m_busy = 0; m_valid = 1; end
        end
      end else begin
        if (wr_en && wr_addr < BITS) mw[wr_bank][wr_addr] = int'(wr_data);
        if (start) begin
          t_acc = cyc;
          for (int c = 0; c < CH; c++) begin
            s = 0;
            for (int n = 0; n < BITS; n++)
              if (vin[c*BITS + n]) s += mw[model][n];
            s = (s + (1 << (SB - 1))) >> SB;
            res[c] = (s > 4095) ? 4095 : s;
          end
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("vout", 64'(vout), 64'(m_vout));
    end
  end

  function automatic logic [CH*BITS-1:0] r36();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[CH*BITS-1:0];
  endfunction

  // n = cycle offset from the accept edge at which valid was seen (60 = never).
  task automatic run_conv(input logic [CH*BITS-1:0] v, input logic m, output int n);
    @(negedge clk); vin = v; model = m; start = 1;
    @(negedge clk); start = 0; n = 1;
    while (valid !== 1'b1 && n < 60) begin
      vin = r36(); model = 1'($urandom);
      @(negedge clk); n++;
    end
  endtask

  task automatic wr(input logic b, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); wr_en = 1; wr_bank = b; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    int n, vcnt, vat;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_vout", 64'(vout), 64'd0);
    rst_n = 1;

    run_conv(36'h001_800_FFF, 1'b0, n);
    chk("ideal_latency", 64'(n), 64'd37);
    chk("ideal_vout", 64'(vout), 64'h001800FFF);

    wr(1'b1, 4'd0, 16'h0018);
    run_conv(36'h000_000_001, 1'b1, n);
    chk("bank1_w0_ch0", 64'(vout[11:0]), 64'h002);
    run_conv(36'h000_000_001, 1'b0, n);
    chk("bank0_w0_ch0", 64'(vout[11:0]), 64'h001);

    wr(1'b0, 4'd15, 16'h0000);
    wr(1'b0, 4'd11, 16'hFFFF);
    run_conv(36'h000_000_FFF, 1'b0, n);
    chk("saturate_ch0", 64'(vout[11:0]), 64'hFFF);

    do_reset();
    @(negedge clk); vin = 36'h000_000_008; model = 0; start = 1;
    @(negedge clk); start = 0; n = 1;
    repeat (4) begin @(negedge clk); n++; end
    start = 1; wr_en = 1; wr_bank = 0; wr_addr = 4'd3; wr_data = '0;
    @(negedge clk); start = 0; wr_en = 0; n++;
    vcnt = 0; vat = 0;
    while (n < 60) begin
      if (valid === 1'b1) begin vcnt++; if (vat == 0) vat = n; end
      @(negedge clk); n++;
    end
    chk("busy_ignore_valids", 64'(vcnt), 64'd1);
    chk("busy_ignore_latency", 64'(vat), 64'd37);
    run_conv(36'h000_000_008, 1'b0, n);
    chk("w3_unchanged", 64'(vout[11:0]), 64'h008);

    @(negedge clk); vin = 36'hABC_123_FFF; model = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_vout", 64'(vout), 64'd0);
    rst_n = 1;
    vcnt = 0;
    repeat (45) begin @(negedge clk); if (valid === 1'b1) vcnt++; end
    chk("abort_no_valid", 64'(vcnt), 64'd0);

    run_conv(36'h00F_0F0_F00, 1'b0, n);
    chk("b2b_first_latency", 64'(n), 64'd37);
    chk("b2b_busy_gap", 64'(busy), 64'd0);
    vin = 36'h5A5_A5A_3C3; model = 0; start = 1;
    @(negedge clk); start = 0; n = 1;
    chk("b2b_restart_busy", 64'(busy), 64'd1);
    while (valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("b2b_second_latency", 64'(n), 64'd37);
    chk("b2b_second_vout", 64'(vout), 64'h5A5A5A3C3);

    for (int i = 0; i < BITS; i++) wr(1'b1, 4'(i), 16'($urandom_range(16'h0010, 16'hF000)));
    repeat (2) begin
      run_conv(r36(), 1'b1, n);
      chk("custom_latency", 64'(n), 64'd37);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sid_dac_seq.md
SID_DAC_SEQ -- requirements
Module: sid_dac_seq

Interface
REQ-001 SHALL have parameter BITS, default 12, DAC input/output width per channel (legal 4..16).
REQ-002 SHALL have parameter CHANNELS, default 3, number of time-multiplexed DAC channels (legal 1..8).
REQ-003 SHALL have parameter SCALEBITS, default 4, fractional bits of each ladder weight.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  conversion request; sampled only while busy=0.
REQ-007 model  input  1  weight bank select (0 = 6581 bank, 1 = 8580 bank); latched with start.
REQ-008 vin  input  CHANNELS*BITS  channel c occupies bits [c*BITS +: BITS]; latched with start.
REQ-009 wr_en  input  1  weight write strobe.
REQ-010 wr_bank  input  1  weight bank for the write.
REQ-011 wr_addr  input  $clog2(BITS)  ladder bit index for the write; values >= BITS are dropped.
REQ-012 wr_data  input  BITS+SCALEBITS  unsigned weight value.
REQ-013 busy  output  1  conversion in progress.
REQ-014 valid  output  1  one-cycle pulse: all channels of vout updated.
REQ-015 vout  output  CHANNELS*BITS  registered converted values, same packing as vin.

Function
REQ-016 SHALL hold two banks of BITS weights each (BITS+SCALEBITS bits); weight n is the scaled voltage contribution of ladder bit n.
REQ-017 FSM states IDLE, RUN; IDLE->RUN on start=1 in IDLE; RUN->IDLE after the last bit of the last channel.
REQ-018 On start accepted at edge T: latch vin and model, clear accumulator, channel counter=0, bit counter=0; busy=1 from T+1.
REQ-019 In RUN, one bit per cycle, bit 0 to BITS-1, channel 0 to CHANNELS-1: acc += vin_lat[c][n] ? w[model_lat][n] : 0.
REQ-020 Accumulator width BITS+SCALEBITS+$clog2(BITS)+1; no overflow is possible.
REQ-021 At the end of channel c: result = (acc + 2^(SCALEBITS-1)) >> SCALEBITS, saturated to 2^BITS-1; written to vout[c]; acc cleared for the next channel.
REQ-022 vout[c] SHALL be visible at T+(c+1)*BITS+1; other channels hold their previous values until their own update.
REQ-023 valid=1 and busy=0 at exactly cycle T+CHANNELS*BITS+1 (default: T+37); valid=0 otherwise.
REQ-024 start while busy=1 is ignored; start in the valid cycle is accepted (back-to-back, no idle gap).
REQ-025 Weight write at edge E with busy=0: w[wr_bank][wr_addr]=wr_data, visible from E+1; a write at the start-accept edge is used by that conversion.
REQ-026 Weight writes while busy=1 are dropped; weights stay unchanged.
REQ-027 Changes to vin and model during RUN do not affect the conversion in progress.

Reset
REQ-028 rst_n=0 at an edge: state=IDLE, busy=0, valid=0, vout=0, counters=0, acc=0, latched inputs=0.
REQ-029 Reset SHALL load both banks with ideal binary weights w[n]=2^(n+SCALEBITS), giving vout=vin; the 6581/8580 tables are loaded by software after reset.
REQ-030 Reset mid-conversion aborts it: no valid pulse, vout=0, weights restored per REQ-029.

Verification
REQ-031 After reset, defaults, vin={ch2=0x001, ch1=0x800, ch0=0xFFF}, start at T -> busy during T+1..T+36; valid at T+37; vout equals vin.
REQ-032 Write bank1 w[0]=0x0018, model=1, vin ch0=0x001 -> vout ch0=0x002; the same conversion with model=0 -> 0x001.
REQ-033 Write bank0 w[11]=0xFFFF, vin ch0=0xFFF, model=0 -> vout ch0=0xFFF (saturated), no wrap.
REQ-034 start at T, then start and wr_en (bank0 w[3]=0) at T+5 -> no restart; w[3] still 0x0080; single valid at T+37.
REQ-035 start at T, rst_n=0 at T+10 -> busy=0 and vout=0 at T+11; no valid pulse follows.
REQ-036 start re-asserted in the valid cycle -> second conversion; busy stays low for only that cycle; second valid 37 cycles later.
